// File: rtl/mac_pkg.sv
// Shared types and default sizes for the signed MAC dot-product sequencer.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        OUTPUT = 2'd2
    } mac_state_e;

    localparam int MAC_WIDTH     = 10;
    localparam int MAC_ACC_WIDTH = 20;
    localparam int MAC_VEC_LEN   = 3;

endpackage

// File: rtl/mac_datapath.sv
// Two-stage signed MAC: stage 1 registers the operand pair, stage 2 adds the
// sign-extended full-width product into a wrapping accumulator and tracks a
// per-vector sticky signed-overflow flag.
module mac_datapath
    import mac_pkg::*;
#(
    parameter int WIDTH     = MAC_WIDTH,
    parameter int ACC_WIDTH = MAC_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_i,   // capture a pair this cycle
    input  logic                        clear_i,  // zero accumulator and flag
    input  logic                        drop_i,   // discard in-flight product
    input  logic signed [WIDTH-1:0]     a_i,
    input  logic signed [WIDTH-1:0]     b_i,
    output logic signed [ACC_WIDTH-1:0] acc_o,
    output logic                        ovf_o
);

    localparam int PW = 2 * WIDTH;

    logic signed [WIDTH-1:0]     a_q, b_q;
    logic                        p_vld_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        ovf_q;

    logic signed [PW-1:0]        a_ext, b_ext, prod;
    logic signed [ACC_WIDTH-1:0] prod_ext, sum_d;
    logic                        ovf_now;

    // Full-precision product, sign-extended sum and signed-overflow detect.
    always_comb begin
        a_ext    = PW'(a_q);
        b_ext    = PW'(b_q);
        prod     = a_ext * b_ext;
        prod_ext = ACC_WIDTH'(prod);
        sum_d    = acc_q + prod_ext;
        ovf_now  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (sum_d[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end

    // Stage 1: operand capture; the valid bit lives exactly one cycle per pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            p_vld_q <= 1'b0;
        end else if (drop_i) begin
            p_vld_q <= 1'b0;
        end else if (load_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            p_vld_q <= 1'b1;
        end else begin
            p_vld_q <= 1'b0;
        end
    end

    // Stage 2: accumulate; a clear wins over any product still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (p_vld_q) begin
            acc_q <= sum_d;
            ovf_q <= ovf_q | ovf_now;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: counts VEC_LEN accepted operand pairs, lets the last
// product settle in the accumulator, then holds the result on a valid/ready
// port until the consumer takes it.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int WIDTH     = MAC_WIDTH,
    parameter int ACC_WIDTH = MAC_ACC_WIDTH,
    parameter int VEC_LEN   = MAC_VEC_LEN,
    parameter int CNT_WIDTH = $clog2(VEC_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [WIDTH-1:0]     in_a,
    input  logic signed [WIDTH-1:0]     in_b,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        abort,
    output logic signed [ACC_WIDTH-1:0] out_f,
    output logic                        out_ovf,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VEC_LEN - 1);

    mac_state_e                  state_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic                        out_valid_q;
    logic signed [ACC_WIDTH-1:0] out_f_q;
    logic                        out_ovf_q;

    logic                        accept, hs, abort_eff;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        ovf;

    // Handshakes; abort is ignored once a result is waiting to be consumed.
    always_comb begin
        in_ready  = (state_q == ACCUM) && !abort;
        accept    = in_valid && in_ready;
        hs        = out_valid_q && out_ready;
        abort_eff = abort && (state_q != OUTPUT);
    end

    mac_datapath #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept),
        .clear_i(abort_eff || hs),
        .drop_i (abort_eff),
        .a_i    (in_a),
        .b_i    (in_b),
        .acc_o  (acc),
        .ovf_o  (ovf)
    );

    // Control FSM with element counter and registered result port. The first
    // OUTPUT cycle samples the settled accumulator into the output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (abort) begin
                        cnt_q <= '0;
                    end else if (accept) begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == LAST) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= ACCUM;
                    end else begin
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_f_q     <= acc;
                        out_ovf_q   <= ovf;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ACCUM;
                    end
                end
                default: begin
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    state_q     <= ACCUM;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (state_q != ACCUM) || (cnt_q != '0);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a transaction-level reference
// model and per-cycle output comparison.
module tb_mac_dot_sequencer;

    localparam int W    = 10;
    localparam int AW   = 20;
    localparam int VLEN = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [W-1:0]  in_a, in_b;
    logic                 in_valid, in_ready, abort;
    logic signed [AW-1:0] out_f;
    logic                 out_ovf, out_valid, out_ready, busy;

    mac_dot_sequencer #(.WIDTH(W), .ACC_WIDTH(AW), .VEC_LEN(VLEN)) dut (
        .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b),
        .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
        .out_f(out_f), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct { longint f; bit o; } res_t;
    res_t   expq[$];
    res_t   got[$];
    longint part_acc = 0;
    bit     part_ovf = 0;
    int     part_cnt = 0;
    bit     pending  = 0;
    bit     drain    = 0;
    int     cyc      = 0;
    int     done_cyc = 0;

    localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW - 1));

    function automatic longint wrap(input longint x);
        longint m;
        m = x & ((64'sd1 <<< AW) - 1);
        if (m > MAXV) m = m - (64'sd1 <<< AW);
        return m;
    endfunction

    task automatic clear_part();
        part_acc = 0; part_ovf = 0; part_cnt = 0;
    endtask

    // Compare at negedge, then advance the model at the following posedge.
    initial begin : monitor
        bit s_acc, s_hs, s_abort, nxt_drain;
        int s_a, s_b;
        longint full, s_f;
        bit s_o;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("in_ready", in_ready, !pending && !abort);
                check("busy", busy, pending || (part_cnt != 0));
                check("out_valid", out_valid, pending && (cyc >= done_cyc + 3));
                if (out_valid && expq.size() > 0) begin
                    check("out_f", out_f, expq[0].f);
                    check("out_ovf", out_ovf, expq[0].o);
                end
            end
            s_acc = in_valid && in_ready;
            s_hs = out_valid && out_ready;
            s_abort = abort;
            s_a = in_a; s_b = in_b;
            s_f = out_f; s_o = out_ovf;
            @(posedge clk);
            if (reset) begin
                expq.delete();
                clear_part();
                pending = 0; drain = 0;
            end else begin
                nxt_drain = 0;
                if (s_abort && drain) begin
                    void'(expq.pop_back());
                    pending = 0;
                    clear_part();
                end else if (s_abort && !pending) begin
                    clear_part();
                end
                if (s_hs) begin
                    got.push_back('{s_f, s_o});
                    if (expq.size() > 0) void'(expq.pop_front());
                    pending = 0;
                end
                if (s_acc) begin
                    full = part_acc + longint'(s_a) * longint'(s_b);
                    if (full > MAXV || full < MINV) part_ovf = 1;
                    part_acc = wrap(full);
                    part_cnt++;
                    if (part_cnt == VLEN) begin
                        expq.push_back('{part_acc, part_ovf});
                        pending = 1;
                        done_cyc = cyc;
                        nxt_drain = 1;
                        clear_part();
                    end
                end
                drain = nxt_drain;
            end
            cyc++;
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int a, input int b);
        bit ok = 0;
        in_a = W'(a); in_b = W'(b); in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int lim);
        int t = 0;
        while ((pending || expq.size() != 0) && t < lim) begin
            @(posedge clk); #1; t++;
        end
        check("result_drained", longint'(pending) + expq.size(), 0);
    endtask

    localparam int NRES = 11;
    int exp_f [NRES] = '{-21, 14, -300, -262144, 3, 44, 3, 3, -18, 22, -411};
    bit exp_o [NRES] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        reset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_f", out_f, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // 1: basic vector
        send(2, 3); send(-4, 5); send(7, -1);
        wait_done(20);

        // 2: gaps and backpressure, then a fresh vector
        out_ready = 1'b0;
        send(1, 1); idle(2); send(2, 2); idle(2); send(3, 3);
        for (int t = 0; t < 10 && !out_valid; t++) begin @(posedge clk); #1; end
        check("bp_valid_seen", out_valid, 1);
        idle(5);
        out_ready = 1'b1;
        wait_done(20);
        send(10, -10); send(10, -10); send(10, -10);
        wait_done(20);

        // 3: overflow, then a clean vector
        send(-512, -512); send(-512, -512); send(-512, -512);
        wait_done(20);
        send(1, 1); send(1, 1); send(1, 1);
        wait_done(20);

        // 4: abort beats in_valid
        send(5, 5); send(6, 6);
        in_a = 10'sd7; in_b = 10'sd7; in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        send(1, 2); send(3, 4); send(5, 6);
        wait_done(20);

        // 5: asynchronous reset mid-vector
        send(9, 9);
        #1 reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        send(1, 1); send(1, 1); send(1, 1);
        wait_done(20);

        // 6: back-to-back vectors with in_valid and out_ready high
        send(1, 1); send(1, 1); send(1, 1);
        send(2, -3); send(2, -3); send(2, -3);
        send(-5, 4); send(6, 7); send(0, 9);
        send(511, 511); send(-512, 511); send(100, 1);
        wait_done(30);
        idle(3);

        // Literal expectations for every consumed result, in order.
        check("result_count", got.size(), NRES);
        for (int i = 0; i < NRES; i++) begin
            if (i < got.size()) begin
                check($sformatf("lit_f[%0d]", i), got[i].f, exp_f[i]);
                check($sformatf("lit_ovf[%0d]", i), got[i].o, exp_o[i]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
Sequencer for the two-stage signed MAC datapath. Accepts a stream of (a,b) operand pairs under valid/ready and feeds them to the MAC. Counts VEC_LEN elements per dot product, clears the accumulator between vectors, and presents each finished dot product on a valid/ready result port with backpressure. Sits between an operand source (memory reader or testbench) and a result consumer.

Parameters:
WIDTH, 10, signed operand width of a and b
ACC_WIDTH, 20, signed accumulator/result width; must be >= 2*WIDTH
VEC_LEN, 3, elements per dot product; must be >= 1
CNT_WIDTH, $clog2(VEC_LEN+1), element counter width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
in_a  in  WIDTH  signed operand a
in_b  in  WIDTH  signed operand b
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts pair this cycle
abort  in  1  synchronous: discard the partial vector
out_f  out  ACC_WIDTH  signed dot-product result
out_ovf  out  1  signed overflow occurred in this result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
busy  out  1  high when state != ACCUM or cnt != 0

Behaviour:
- Reset (async, active-high): state=ACCUM, cnt=0, acc=0, stage-1 regs a_r=b_r=0, p_vld=0, ovf_sticky=0. Outputs: in_ready=1 after reset deasserts, out_valid=0, out_f=0, out_ovf=0, busy=0.
- States: ACCUM, DRAIN, OUTPUT.
- Accept = in_valid & in_ready. in_ready = (state==ACCUM) & !abort (combinational).
- ACCUM: on accept, capture a_r<=in_a, b_r<=in_b, p_vld<=1, cnt<=cnt+1. When accepting with cnt==VEC_LEN-1, go to DRAIN. Gaps in in_valid are allowed with no effect.
- Stage 2: when p_vld==1, acc <= acc + sext(a_r*b_r). The product is a full 2*WIDTH signed product, sign-extended to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH.
- Overflow: ovf_sticky is set when the operands' signs are equal and the sum's sign differs. The flag is sticky per vector.
- p_vld clears on any cycle with no accept.
- DRAIN: lasts exactly one cycle, during which the last product is accumulated. Then go to OUTPUT.
- Latency: the last element is accepted at edge E. out_valid rises after edge E+2, and out_f at that point includes the last product.
- OUTPUT: out_valid=1, out_f=acc, out_ovf=ovf_sticky. Both are held stable while out_ready=0.
- On out_valid & out_ready: acc<=0, ovf_sticky<=0, cnt<=0, go to ACCUM. in_ready returns the following cycle. There is no same-cycle accept in OUTPUT.
- abort in ACCUM or DRAIN: next state ACCUM, cnt=0, acc=0, p_vld=0, ovf_sticky=0. Any in-flight product is dropped. abort beats a simultaneous in_valid because in_ready is forced to 0.
- abort in OUTPUT: ignored. The result must still be consumed.
- VEC_LEN=1: ACCUM goes to DRAIN on every accept.
- Reset mid-operation: return immediately to the reset values above. The partial vector and any pending result are lost.

Decomposition:
- Package mac_pkg: the state enum (ACCUM/DRAIN/OUTPUT) and default constants MAC_WIDTH=10, MAC_ACC_WIDTH=20.
- Sub-module mac_datapath: holds the stage-1 operand registers, p_vld, the stage-2 accumulator, and overflow detection. Its controls are load, clear, and drop.
- The FSM, counter and handshakes stay in mac_dot_sequencer.

Test Plan:
1. Basic vector: VEC_LEN=3; pairs (2,3),(-4,5),(7,-1) on consecutive cycles; out_ready=1. Required: out_valid rises 2 edges after the 3rd accept, out_f=-21, out_ovf=0, in_ready=0 during DRAIN/OUTPUT.
2. Backpressure and gaps: pairs (1,1),(2,2),(3,3) with 2 idle cycles between them; hold out_ready=0 for 5 cycles. Required: out_f=14 held stable, in_ready=0 throughout. Second vector (10,-10)x3 then gives out_f=-300, confirming acc was cleared.
3. Overflow: three pairs (-512,-512). Required: out_f=-262144 (786432 wrapped to 20 bits), out_ovf=1. Next vector (1,1)x3 gives out_f=3, out_ovf=0.
4. Abort: accept (5,5),(6,6), then assert abort together with in_valid=1. Required: in_ready=0 that cycle. Then (1,2),(3,4),(5,6) gives out_f=44.
5. Reset mid-vector: accept (9,9), assert reset asynchronously between edges. Required: out_valid=0, busy=0, in_ready=1 after release. Then (1,1)x3 gives out_f=3.
6. Back-to-back: 4 vectors with in_valid and out_ready tied high. Required: each result appears exactly once, in order, and in_ready resumes 1 cycle after each result handshake.
